regfile_sb: RTL and testbench

- Parametrised integer register file with an integrated write-pending scoreboard, for the pipelined core.
- Provides NUM_READ combinational read ports and one synchronous write port; register 0 is hardwired to zero.
- Tracks which destination registers have an issued but not yet written-back result.
- Decode uses the scoreboard to stall on RAW/WAW hazards.

---
 rtl/regfile_sb.sv | 60 ++++++
 tb/tb_regfile_sb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with write-pending scoreboard; RF_BYPASS_EN enables same-cycle writeback forwarding.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_READ = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         iss_valid,
  input  logic [ADDR_W-1:0]            iss_rd,
  output logic                         iss_ready,
  output logic [ADDR_W:0]              busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy, set_v, clr_v;
  logic              wr_hit, acc, inc, dec;
  assign wr_hit = wr_en && wr_addr != '0;
`ifdef RF_BYPASS_EN
  assign iss_ready = iss_rd == '0 || !busy[iss_rd] || (wr_en && wr_addr == iss_rd);
`else
  assign iss_ready = iss_rd == '0 || !busy[iss_rd];
`endif
  assign acc = iss_valid && iss_ready && iss_rd != '0;
  assign set_v = acc ? {{(DEPTH-1){1'b0}}, 1'b1} << iss_rd : '0;
  assign clr_v = wr_hit ? {{(DEPTH-1){1'b0}}, 1'b1} << wr_addr : '0;
  // Counter tracks the popcount: a set on an already-busy reg and a clear it overrides are both net zero.
  assign inc = acc && !busy[iss_rd];
  assign dec = wr_hit && busy[wr_addr] && !(acc && iss_rd == wr_addr);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_hit) regs[wr_addr] <= wr_data;
      busy <= (busy & ~clr_v) | set_v;
      busy_cnt <= busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end
  end
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
    logic hit;
    assign hit = wr_en && wr_addr == a;
    assign rd_data[i*DATA_W +: DATA_W] = a == '0 ? '0 : hit ? wr_data : regs[a];
    assign rd_busy[i] = a != '0 && !hit && busy[a];
`else
    assign rd_data[i*DATA_W +: DATA_W] = a == '0 ? '0 : regs[a];
    assign rd_busy[i] = a != '0 && busy[a];
`endif
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb (default or RF_BYPASS_EN build).
module tb_regfile_sb;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 0, reset = 1, wr_en = 0, iss_valid = 0, iss_ready;
  logic [4:0]  wr_addr = 0, iss_rd = 0;
  logic [31:0] wr_data = 0;
  logic [9:0]  rd_addr = 0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  busy_cnt;
  int n_cmp = 0, n_err = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_rd_busy", rd_busy, 2'b00);
    chk("rst_iss_ready", iss_ready, 1'b1);
    chk("rst_busy_cnt", busy_cnt, 6'd0);
    #10 reset = 0;
    cyc;
    // write/read on both ports, r0 stays zero
    wr_en = 1; wr_addr = 5; wr_data = 32'h12345678;
    cyc;
    wr_en = 0; rd_addr = {5'd0, 5'd5}; #1;
    chk("rd_p0_r5", rd_data[31:0], 32'h12345678);
    chk("rd_p1_r0", rd_data[63:32], 32'h0);
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    cyc;
    wr_en = 0; rd_addr = {5'd5, 5'd0}; #1;
    chk("rd_p0_r0_after_wr", rd_data[31:0], 32'h0);
    chk("rd_p1_r5", rd_data[63:32], 32'h12345678);
    // scoreboard basic
    iss_valid = 1; iss_rd = 3; #1;
    chk("iss_r3_ready", iss_ready, 1'b1);
    cyc;
    rd_addr = {5'd0, 5'd3}; #1;
    chk("cnt_after_r3", busy_cnt, 6'd1);
    chk("busy_r3", rd_busy, 2'b01);
    chk("iss_r3_waw", iss_ready, 1'b0);
    cyc;
    chk("cnt_r3_hold", busy_cnt, 6'd1);
    iss_valid = 0; wr_en = 1; wr_addr = 3; wr_data = 32'h33; #1;
    chk("iss_ready_wb_same_cycle", iss_ready, BYP);
    chk("rd_busy_wb_same_cycle", rd_busy, {1'b0, ~BYP});
    cyc;
    wr_en = 0; #1;
    chk("cnt_after_wb_r3", busy_cnt, 6'd0);
    chk("iss_ready_after_wb", iss_ready, 1'b1);
    chk("busy_r3_clear", rd_busy, 2'b00);
    chk("rd_r3", rd_data[31:0], 32'h33);
    // simultaneous set/clear on busy r4
    iss_valid = 1; iss_rd = 4;
    cyc;
    chk("cnt_r4", busy_cnt, 6'd1);
    wr_en = 1; wr_addr = 4; wr_data = 32'hA5; #1;
    chk("iss_r4_ready_sc", iss_ready, BYP);
    cyc;
    wr_en = 0; iss_valid = 0; rd_addr = {5'd0, 5'd4}; #1;
    chk("rd_r4", rd_data[31:0], 32'hA5);
    chk("busy_r4_sc", rd_busy, {1'b0, BYP});
    chk("cnt_r4_sc", busy_cnt, BYP ? 6'd1 : 6'd0);
    wr_en = 1; wr_addr = 4;
    cyc;
    wr_en = 0; #1;
    chk("cnt_r4_cleared", busy_cnt, 6'd0);
    // simultaneous set/clear on non-busy r8: set wins
    wr_en = 1; wr_addr = 8; wr_data = 32'h88; iss_valid = 1; iss_rd = 8; rd_addr = {5'd0, 5'd8}; #1;
    chk("iss_r8_ready", iss_ready, 1'b1);
    cyc;
    wr_en = 0; iss_valid = 0; #1;
    chk("cnt_r8_set_wins", busy_cnt, 6'd1);
    chk("busy_r8_set_wins", rd_busy, 2'b01);
    chk("rd_r8", rd_data[31:0], 32'h88);
    wr_en = 1; wr_addr = 8;
    cyc;
    wr_en = 0; #1;
    chk("cnt_r8_cleared", busy_cnt, 6'd0);
    // bypass behaviour on r6
    wr_en = 1; wr_addr = 6; wr_data = 32'h11;
    cyc;
    wr_en = 0; iss_valid = 1; iss_rd = 6;
    cyc;
    iss_valid = 0; wr_en = 1; wr_addr = 6; wr_data = 32'h22; rd_addr = {5'd0, 5'd6}; #1;
    chk("byp_rd_data", rd_data[31:0], BYP ? 32'h22 : 32'h11);
    chk("byp_rd_busy", rd_busy, {1'b0, ~BYP});
    cyc;
    wr_en = 0; #1;
    chk("byp_next_rd", rd_data[31:0], 32'h22);
    chk("byp_next_busy", rd_busy, 2'b00);
    // fill all 31 and drain in reverse
    for (int r = 1; r < 32; r++) begin
      iss_valid = 1; iss_rd = 5'(r);
      cyc;
    end
    iss_valid = 0; iss_rd = 31; #1;
    chk("fill_cnt", busy_cnt, 6'd31);
    chk("fill_r31_not_ready", iss_ready, 1'b0);
    iss_rd = 0; #1;
    chk("fill_r0_ready", iss_ready, 1'b1);
    for (int r = 31; r >= 1; r--) begin
      wr_en = 1; wr_addr = 5'(r); wr_data = 32'(r);
      cyc;
      chk($sformatf("drain_cnt_%0d", r), busy_cnt, 6'(r - 1));
    end
    wr_addr = 1;
    cyc;
    wr_en = 0; #1;
    chk("no_underflow", busy_cnt, 6'd0);
    // reset mid-run
    wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF;
    cyc;
    wr_en = 0; iss_valid = 1; iss_rd = 9;
    cyc;
    iss_valid = 0; rd_addr = {5'd9, 5'd7}; #1;
    chk("pre_rst_r7", rd_data[31:0], 32'hDEADBEEF);
    chk("pre_rst_cnt", busy_cnt, 6'd1);
    chk("pre_rst_busy", rd_busy, 2'b10);
    #1 reset = 1; #1;
    chk("mid_rst_rd_data", rd_data, 64'h0);
    chk("mid_rst_cnt", busy_cnt, 6'd0);
    chk("mid_rst_busy", rd_busy, 2'b00);
    chk("mid_rst_iss_ready", iss_ready, 1'b1);
    #1 reset = 0;
    cyc;
    rd_addr = {5'd0, 5'd5}; #1;
    chk("post_rst_r5", rd_data[31:0], 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
